gtfwizard_0_gtf_ch_drp_responder: RTL

- Synthesizable DRP responder (slave) that stands in for the GTF channel DRP port.
- Accepts single-access read, write and read-modify-write sequences from the channel DRP initiators, including the RX buffer-bypass alignment-switch reconfiguration sequencer.
- Backs a register window with a 16-bit storage array and returns drprdy after a programmable latency.
- Flags protocol violations and exposes a side monitor read port for the bench and ILA.

---
 rtl/gtfwizard_0_gtf_ch_drp_responder_if.sv | 20 ++
 rtl/gtfwizard_0_gtf_ch_drp_responder.sv | 110 +++++++++++
 2 files changed

// File: rtl/gtfwizard_0_gtf_ch_drp_responder_if.sv
// DRP handshake bundle between a channel DRP initiator (master) and the
// register-window responder (slave).
interface gtfwizard_0_gtf_ch_drp_responder_if;
  logic        drpen_in;
  logic        drpwe_in;
  logic [9:0]  drpaddr_in;
  logic [15:0] drpdi_in;
  logic        drprdy_out;
  logic [15:0] drpdo_out;

  modport master (
    output drpen_in, drpwe_in, drpaddr_in, drpdi_in,
    input  drprdy_out, drpdo_out
  );

  modport slave (
    input  drpen_in, drpwe_in, drpaddr_in, drpdi_in,
    output drprdy_out, drpdo_out
  );
endinterface

// File: rtl/gtfwizard_0_gtf_ch_drp_responder.sv
// GTF channel DRP stand-in: 16-bit register window answering single accesses
// after a fixed latency, with sticky protocol/range flags and a monitor port.
module gtfwizard_0_gtf_ch_drp_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned RDY_LATENCY = 4,
  parameter logic [15:0] INIT_DATA   = 16'h0000
) (
  input  logic        freerun_clk_in,
  input  logic        drp_reset_in,
  gtfwizard_0_gtf_ch_drp_responder_if.slave drp,
  output logic        busy_out,
  output logic        protocol_err_out,
  output logic        oor_err_out,
  output logic [15:0] wr_count_out,
  input  logic [9:0]  mon_addr_in,
  output logic [15:0] mon_data_out
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        accept;
  logic [9:0]  cap_addr;
  logic        cap_we;
  logic [15:0] cap_di;
  logic        cap_in_range;
  logic        commit;

  // Storage holds its contents across drp_reset_in; only configuration loads it.
  logic [15:0] mem [DEPTH] = '{default: INIT_DATA};

  function automatic logic in_range(input logic [9:0] a);
    return {1'b0, a} < 11'(DEPTH);
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (drp.drpen_in) begin
          accept  = 1'b1;
          cnt_n   = 4'(RDY_LATENCY - 1);
          state_n = (RDY_LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cap_in_range   = in_range(cap_addr);
    commit         = (state == RESP) && cap_we && cap_in_range && !drp_reset_in;
    busy_out       = (state != IDLE);
    drp.drprdy_out = (state == RESP);
    drp.drpdo_out  = '0;
    if (state == RESP && !cap_we && cap_in_range)
      drp.drpdo_out = mem[cap_addr[AW-1:0]];
  end

  always_ff @(posedge freerun_clk_in) begin
    if (drp_reset_in) begin
      state            <= IDLE;
      cnt              <= '0;
      cap_addr         <= '0;
      cap_we           <= 1'b0;
      cap_di           <= '0;
      protocol_err_out <= 1'b0;
      oor_err_out      <= 1'b0;
      wr_count_out     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        cap_addr <= drp.drpaddr_in;
        cap_we   <= drp.drpwe_in;
        cap_di   <= drp.drpdi_in;
      end
      // Requests arriving outside IDLE (including the RESP cycle) are dropped.
      if ((drp.drpen_in && state != IDLE) || (drp.drpwe_in && !drp.drpen_in))
        protocol_err_out <= 1'b1;
      if (accept && !in_range(drp.drpaddr_in))
        oor_err_out <= 1'b1;
      if (commit && wr_count_out != '1)
        wr_count_out <= wr_count_out + 16'd1;
    end
  end

  always_ff @(posedge freerun_clk_in) begin
    if (commit)
      mem[cap_addr[AW-1:0]] <= cap_di;
  end

  always_ff @(posedge freerun_clk_in) begin
    if (drp_reset_in)
      mon_data_out <= '0;
    else
      mon_data_out <= in_range(mon_addr_in) ? mem[mon_addr_in[AW-1:0]] : '0;
  end

endmodule
